// File: rtl/vga_fb_arbiter.sv
// Time-slot arbiter sharing a single-port framebuffer RAM between VGA scanout
// (phase 0 cycles) and CPU read/write requests (phase 1 cycles).
module vga_fb_arbiter #(
    parameter int unsigned H_BEGIN     = 143,
    parameter int unsigned V_BEGIN     = 34,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SCALE_SHIFT = 3,
    parameter int unsigned ADDR_W      = 13
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [9:0]        i_disp_h,
    input  logic [9:0]        i_disp_v,
    output logic [2:0]        o_disp_rgb,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [2:0]        i_cpu_wdata,
    output logic [2:0]        o_cpu_rdata,
    output logic              o_cpu_ack,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [2:0]        o_mem_wdata,
    input  logic [2:0]        i_mem_rdata
);

    localparam int unsigned COLS  = H_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned ROWS  = V_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned CELLS = COLS * ROWS;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StAck
    } cpu_state_e;

    cpu_state_e        r_state;
    logic              r_phase;
    logic              r_disp_act;
    logic [2:0]        r_disp_rgb;
    logic              r_rd_in_range;
    logic [2:0]        r_cpu_rdata;
    logic              r_cpu_ack;

    logic [9:0]        w_h_off;
    logic [9:0]        w_v_off;
    logic              w_h_act;
    logic              w_v_act;
    logic              w_disp_active;
    logic [ADDR_W-1:0] w_cell;
    logic              w_cpu_in_range;
    logic              w_cpu_issue;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_we;
    logic [2:0]        w_mem_wdata;

    // Offsets wrap at 10 bits; the active window keeps them meaningful.
    assign w_h_off = i_disp_h - 10'(H_BEGIN);
    assign w_v_off = i_disp_v - 10'(V_BEGIN);

    assign w_h_act = ({1'b0, i_disp_h} >= 11'(H_BEGIN)) &&
                     ({1'b0, i_disp_h} <  11'(H_BEGIN + H_ACTIVE));
    assign w_v_act = ({1'b0, i_disp_v} >= 11'(V_BEGIN)) &&
                     ({1'b0, i_disp_v} <  11'(V_BEGIN + V_ACTIVE));
    assign w_disp_active = w_h_act && w_v_act;

    assign w_cell = ADDR_W'(w_v_off >> SCALE_SHIFT) * ADDR_W'(COLS)
                  + ADDR_W'(w_h_off >> SCALE_SHIFT);

    assign w_cpu_in_range = 32'(i_cpu_addr) < CELLS;
    assign w_cpu_issue    = r_phase && (r_state == StIdle) && i_cpu_req;

    // RAM port mux; forced quiet while reset is asserted.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        if (!i_rst) begin
            if (!r_phase) begin
                if (w_disp_active) begin
                    w_mem_addr = w_cell;
                end
            end else if (w_cpu_issue) begin
                w_mem_addr = i_cpu_addr;
                if (i_cpu_we) begin
                    w_mem_we    = w_cpu_in_range;
                    w_mem_wdata = i_cpu_wdata;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
        end
    end

    // Display path: address in phase 0, capture RAM data in phase 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_disp_act <= 1'b0;
            r_disp_rgb <= '0;
        end else if (!r_phase) begin
            r_disp_act <= w_disp_active;
        end else begin
            r_disp_rgb <= r_disp_act ? i_mem_rdata : 3'b000;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_rd_in_range <= 1'b0;
            r_cpu_rdata   <= '0;
            r_cpu_ack     <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_cpu_issue) begin
                        if (i_cpu_we) begin
                            r_state   <= StAck;
                            r_cpu_ack <= 1'b1;
                        end else begin
                            r_rd_in_range <= w_cpu_in_range;
                            r_state       <= StRdWait;
                        end
                    end
                end
                StRdWait: begin
                    r_cpu_rdata <= r_rd_in_range ? i_mem_rdata : 3'b000;
                    r_state     <= StAck;
                    r_cpu_ack   <= 1'b1;
                end
                StAck: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_disp_rgb  = r_disp_rgb;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_cpu_ack   = r_cpu_ack;
    assign o_mem_addr  = w_mem_addr;
    assign o_mem_we    = w_mem_we;
    assign o_mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vga_fb_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic [9:0]  i_disp_h;
    logic [9:0]  i_disp_v;
    logic [2:0]  o_disp_rgb;
    logic        i_cpu_req;
    logic        i_cpu_we;
    logic [12:0] i_cpu_addr;
    logic [2:0]  i_cpu_wdata;
    logic [2:0]  o_cpu_rdata;
    logic        o_cpu_ack;
    logic [12:0] o_mem_addr;
    logic        o_mem_we;
    logic [2:0]  o_mem_wdata;
    logic [2:0]  i_mem_rdata;

    logic        tb_load;
    logic [2:0]  ram [0:8191];
    int          n_checks;
    int          n_errors;

    vga_fb_arbiter u_dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_disp_h    (i_disp_h),
        .i_disp_v    (i_disp_v),
        .o_disp_rgb  (o_disp_rgb),
        .i_cpu_req   (i_cpu_req),
        .i_cpu_we    (i_cpu_we),
        .i_cpu_addr  (i_cpu_addr),
        .i_cpu_wdata (i_cpu_wdata),
        .o_cpu_rdata (o_cpu_rdata),
        .o_cpu_ack   (o_cpu_ack),
        .o_mem_addr  (o_mem_addr),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Background 010, cell 0 = 110, cell 81 = 011.
    always @(posedge i_clk) begin
        if (tb_load) begin
            for (int i = 0; i < 8192; i++) begin
                ram[i] <= 3'b010;
            end
            ram[0]  <= 3'b110;
            ram[81] <= 3'b011;
            i_mem_rdata <= 3'b000;
        end else begin
            if (o_mem_we) begin
                ram[o_mem_addr] <= o_mem_wdata;
            end
            i_mem_rdata <= ram[o_mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        tb_load     = 1'b1;
        i_rst       = 1'b1;
        i_disp_h    = 10'd143;
        i_disp_v    = 10'd34;
        i_cpu_req   = 1'b0;
        i_cpu_we    = 1'b0;
        i_cpu_addr  = '0;
        i_cpu_wdata = '0;

        next_cycle();
        tb_load = 1'b0;
        mid();
        check_eq("rst_disp_rgb", 32'(o_disp_rgb), 0);
        check_eq("rst_cpu_rdata", 32'(o_cpu_rdata), 0);
        check_eq("rst_cpu_ack", 32'(o_cpu_ack), 0);
        check_eq("rst_mem_we", 32'(o_mem_we), 0);
        check_eq("rst_mem_addr", 32'(o_mem_addr), 0);
        check_eq("rst_mem_wdata", 32'(o_mem_wdata), 0);

        // c0: phase 0, pixel (143,34) -> cell 0
        next_cycle();
        i_rst = 1'b0;
        mid();
        check_eq("c0_mem_addr", 32'(o_mem_addr), 0);
        check_eq("c0_mem_we", 32'(o_mem_we), 0);
        check_eq("c0_ack", 32'(o_cpu_ack), 0);
        next_cycle();
        mid();
        check_eq("c1_mem_we", 32'(o_mem_we), 0);
        check_eq("c1_disp_rgb", 32'(o_disp_rgb), 0);
        // c2: pixel (151,42) -> cell 81
        next_cycle();
        i_disp_h = 10'd151;
        i_disp_v = 10'd42;
        mid();
        check_eq("c2_disp_rgb_cell0", 32'(o_disp_rgb), 32'b110);
        check_eq("c2_mem_addr_81", 32'(o_mem_addr), 81);
        next_cycle();
        mid();
        check_eq("c3_ack", 32'(o_cpu_ack), 0);
        // c4: horizontal blanking
        next_cycle();
        i_disp_h = 10'd100;
        mid();
        check_eq("c4_disp_rgb_cell81", 32'(o_disp_rgb), 32'b011);
        check_eq("c4_mem_we", 32'(o_mem_we), 0);
        next_cycle();
        // c6: CPU write raised in phase 0
        next_cycle();
        i_disp_h    = 10'd151;
        i_cpu_req   = 1'b1;
        i_cpu_we    = 1'b1;
        i_cpu_addr  = 13'd81;
        i_cpu_wdata = 3'b101;
        mid();
        check_eq("c6_disp_rgb_blank", 32'(o_disp_rgb), 0);
        check_eq("c6_mem_we_wait", 32'(o_mem_we), 0);
        check_eq("c6_mem_addr_disp", 32'(o_mem_addr), 81);
        next_cycle();
        mid();
        check_eq("c7_mem_we_issue", 32'(o_mem_we), 1);
        check_eq("c7_mem_addr", 32'(o_mem_addr), 81);
        check_eq("c7_mem_wdata", 32'(o_mem_wdata), 32'b101);
        check_eq("c7_ack", 32'(o_cpu_ack), 0);
        next_cycle();
        mid();
        check_eq("c8_ack_wr", 32'(o_cpu_ack), 1);
        check_eq("c8_mem_we", 32'(o_mem_we), 0);
        check_eq("c8_disp_rgb_old", 32'(o_disp_rgb), 32'b011);
        next_cycle();
        i_cpu_req = 1'b0;
        mid();
        check_eq("c9_ack", 32'(o_cpu_ack), 0);
        check_eq("c9_mem_we", 32'(o_mem_we), 0);
        // c10: CPU read of 81 while display moves to cell 0
        next_cycle();
        i_disp_h   = 10'd143;
        i_disp_v   = 10'd34;
        i_cpu_req  = 1'b1;
        i_cpu_we   = 1'b0;
        i_cpu_addr = 13'd81;
        mid();
        check_eq("c10_disp_rgb_new", 32'(o_disp_rgb), 32'b101);
        check_eq("c10_mem_addr_disp", 32'(o_mem_addr), 0);
        next_cycle();
        mid();
        check_eq("c11_mem_addr_rd", 32'(o_mem_addr), 81);
        check_eq("c11_mem_we", 32'(o_mem_we), 0);
        check_eq("c11_ack", 32'(o_cpu_ack), 0);
        next_cycle();
        mid();
        check_eq("c12_ack", 32'(o_cpu_ack), 0);
        check_eq("c12_mem_addr_disp", 32'(o_mem_addr), 0);
        check_eq("c12_disp_rgb", 32'(o_disp_rgb), 32'b110);
        next_cycle();
        mid();
        check_eq("c13_ack_rd", 32'(o_cpu_ack), 1);
        check_eq("c13_rdata", 32'(o_cpu_rdata), 32'b101);
        // c14: out-of-range write
        next_cycle();
        i_cpu_we    = 1'b1;
        i_cpu_addr  = 13'd4800;
        i_cpu_wdata = 3'b111;
        mid();
        check_eq("c14_ack", 32'(o_cpu_ack), 0);
        check_eq("c14_rdata_held", 32'(o_cpu_rdata), 32'b101);
        check_eq("c14_disp_rgb", 32'(o_disp_rgb), 32'b110);
        next_cycle();
        mid();
        check_eq("c15_oor_mem_we", 32'(o_mem_we), 0);
        check_eq("c15_oor_mem_addr", 32'(o_mem_addr), 4800);
        check_eq("c15_ack", 32'(o_cpu_ack), 0);
        next_cycle();
        mid();
        check_eq("c16_oor_wr_ack", 32'(o_cpu_ack), 1);
        // c17: out-of-range read issued right after ack
        next_cycle();
        i_cpu_we = 1'b0;
        mid();
        check_eq("c17_mem_we", 32'(o_mem_we), 0);
        check_eq("c17_ack", 32'(o_cpu_ack), 0);
        next_cycle();
        mid();
        check_eq("c18_ack", 32'(o_cpu_ack), 0);
        next_cycle();
        mid();
        check_eq("c19_oor_rd_ack", 32'(o_cpu_ack), 1);
        check_eq("c19_oor_rdata", 32'(o_cpu_rdata), 0);
        // c20: read of 81, reset lands in its wait cycle
        next_cycle();
        i_cpu_addr = 13'd81;
        mid();
        check_eq("c20_ack", 32'(o_cpu_ack), 0);
        next_cycle();
        mid();
        check_eq("c21_mem_addr_rd", 32'(o_mem_addr), 81);
        next_cycle();
        i_rst = 1'b1;
        mid();
        check_eq("c22_rst_mem_we", 32'(o_mem_we), 0);
        next_cycle();
        i_rst = 1'b0;
        mid();
        check_eq("c23_ack", 32'(o_cpu_ack), 0);
        check_eq("c23_disp_rgb", 32'(o_disp_rgb), 0);
        check_eq("c23_rdata", 32'(o_cpu_rdata), 0);
        check_eq("c23_mem_we", 32'(o_mem_we), 0);
        check_eq("c23_mem_addr", 32'(o_mem_addr), 0);
        check_eq("c23_mem_wdata", 32'(o_mem_wdata), 0);
        next_cycle();
        mid();
        check_eq("c24_mem_addr_rd", 32'(o_mem_addr), 81);
        check_eq("c24_ack", 32'(o_cpu_ack), 0);
        next_cycle();
        mid();
        check_eq("c25_ack", 32'(o_cpu_ack), 0);
        check_eq("c25_disp_rgb", 32'(o_disp_rgb), 32'b110);
        next_cycle();
        mid();
        check_eq("c26_ack_rd", 32'(o_cpu_ack), 1);
        check_eq("c26_rdata", 32'(o_cpu_rdata), 32'b101);
        next_cycle();
        i_cpu_req = 1'b0;
        mid();
        check_eq("c27_ack", 32'(o_cpu_ack), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between VGA scanout reads and CPU read/write requests.
- Uses fixed time slots. Phase 0 cycles belong to the display. Phase 1 cycles belong to the CPU.
- Converts raw VGA counters to a cell address at reduced resolution and returns the 3-bit pixel colour for the VGA block's rgb input.
- Sits between the VGA timing block, the CPU bus and the framebuffer RAM. The RAM has 1-cycle read latency.

Parameters:
- H_BEGIN, 143, horizontal counter value of the first active pixel
- V_BEGIN, 34, vertical counter value of the first active line
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- SCALE_SHIFT, 3, log2 of the pixel-to-cell scale factor (8 gives 80x60 cells)
- ADDR_W, 13, framebuffer address width

Ports:
- clk  in  1  system clock, 2x the VGA pixel clock
- rst  in  1  synchronous, active-high reset
- disp_h  in  10  horizontal counter of the pixel to fetch
- disp_v  in  10  vertical counter of the pixel to fetch
- disp_rgb  out  3  fetched pixel colour, registered
- cpu_req  in  1  CPU request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_W  cell address
- cpu_wdata  in  3  write colour
- cpu_rdata  out  3  read data, registered; valid in the cpu_ack cycle and held afterwards
- cpu_ack  out  1  single-cycle completion pulse
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  3  RAM write data
- mem_rdata  in  3  RAM read data, valid the cycle after the address is presented

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - phase = 0, CPU FSM = C_IDLE.
  - disp_rgb = 0, cpu_rdata = 0, cpu_ack = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Phase: toggles every cycle after reset. Integration aligns the rising edge of the VGA pixel clock with phase 0.
- Derived constants:
  - COLS = H_ACTIVE >> SCALE_SHIFT; ROWS = V_ACTIVE >> SCALE_SHIFT.
  - CELLS = COLS * ROWS.
- Display slot (phase 0):
  - Active when H_BEGIN <= disp_h < H_BEGIN+H_ACTIVE and V_BEGIN <= disp_v < V_BEGIN+V_ACTIVE.
  - If active: mem_addr = ((disp_v-V_BEGIN) >> SCALE_SHIFT) * COLS + ((disp_h-H_BEGIN) >> SCALE_SHIFT), and mem_we = 0.
  - Arithmetic is unsigned at 10 bits; the result is truncated to ADDR_W.
  - The active flag is registered for the next cycle.
- Display return (phase 1):
  - If the registered active flag is 1: disp_rgb <= mem_rdata at the end of the cycle. Otherwise disp_rgb <= 0.
  - Latency: disp_rgb reflects the coordinates sampled 2 cycles earlier. The presenter supplies coordinates one pixel ahead.
  - disp_rgb is stable for 2 cycles per pixel.
- CPU FSM states:
  - C_IDLE, phase 1, cpu_req = 1: issue the access in this cycle. mem_addr = cpu_addr.
    - Write: mem_we = 1 only if cpu_addr < CELLS; mem_wdata = cpu_wdata; next state C_ACK.
    - Read: record the range result; next state C_RDWAIT.
  - C_IDLE, phase 0 or cpu_req = 0: stay in C_IDLE.
  - C_RDWAIT (always a phase 0 cycle): cpu_rdata <= mem_rdata if in range, else 0; next state C_ACK.
    - The display slot still drives mem_addr in this cycle.
  - C_ACK: cpu_ack = 1 for exactly this cycle; next state C_IDLE.
- CPU request rules:
  - cpu_req is sampled only in C_IDLE. The requester drops it after seeing cpu_ack.
  - A cpu_req still high in the cycle after cpu_ack is a new request.
  - Out-of-range addresses are still acknowledged. Writes are suppressed and reads return 0.
- Timing:
  - Write: issue at cycle t, ack at t+1. Back-to-back writes run at most every 2 cycles.
  - Read: issue at t, capture at t+1, ack at t+2. Back-to-back reads run at most every 4 cycles.
- Outside the CPU slot, mem_we = 0 always. The display never stalls and the CPU never preempts a display slot.
- Reset during a transaction:
  - The pending transaction is dropped and no ack is issued.
  - A write already issued to RAM stays committed.
  - The FSM returns to C_IDLE with phase 0.

Test Plan:
- Reset, then idle with disp_h=143, disp_v=34: mem_addr=0 and mem_we=0 in phase 0; disp_rgb equals RAM[0] 2 cycles later; cpu_ack stays 0.
- Coordinates disp_h=151, disp_v=42: mem_addr = 1*80+1 = 81. Coordinates disp_h=100 (blanking): disp_rgb=0 and no display read.
- CPU write with cpu_req=1 raised in phase 0, cpu_addr=81, cpu_wdata=3'b101:
  - Issue waits one cycle for phase 1; mem_we=1 for exactly 1 cycle.
  - cpu_ack arrives the next cycle.
  - Display at (151,42) then returns 3'b101.
- CPU read of addr 81 after that write: cpu_ack exactly 2 cycles after issue, cpu_rdata=3'b101. A display read issued in the same window is unaffected.
- Out-of-range access at addr 4800: write is acknowledged with mem_we never 1; read is acknowledged with cpu_rdata=0.
- Assert rst in the C_RDWAIT cycle: no cpu_ack; all outputs 0 the next cycle; a new request then completes normally.
